// File: rtl/div_half_precision.sv
// div_half_precision: iterative IEEE-754 binary16 divider, one quotient bit
// per clock from a radix-2 restoring loop, start/busy/done handshake.
//
// Ports:
//   i_Clk        clock, rising edge
//   i_Reset_n    asynchronous active-low reset
//   i_Start      request, accepted only while o_Busy=0
//   i_Dividend   binary16 dividend, captured on the accepting edge
//   i_Divisor    binary16 divisor, captured on the accepting edge
//   o_Quotient   binary16 result, held until the next o_Done
//   o_Exception  div-by-zero, inf/NaN operand, overflow or underflow
//   o_Busy       high from the accepting edge until the o_Done edge
//   o_Done       one-cycle completion pulse
//
// Build option: define DIV_ROUND_NEAREST_EN for round-to-nearest-even;
// otherwise the quotient fraction is truncated.

module div_half_precision (
    input  logic        i_Clk,
    input  logic        i_Reset_n,
    input  logic        i_Start,
    input  logic [15:0] i_Dividend,
    input  logic [15:0] i_Divisor,
    output logic [15:0] o_Quotient,
    output logic        o_Exception,
    output logic        o_Busy,
    output logic        o_Done
);

    localparam int unsigned ITER = 13;
    localparam int unsigned BIAS = 15;
    localparam int unsigned CW   = 4;

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_NORM, S_DONE} state_t;

    state_t      r_state;
    logic [15:0] r_a;
    logic [15:0] r_b;
    logic [11:0] r_rem;
    logic [12:0] r_q;
    logic [CW-1:0] r_cnt;
    logic [15:0] r_res;
    logic        r_exc;

    // Restoring step: compare, conditionally subtract
    logic [10:0] w_m2;
    logic        w_ge;
    logic [11:0] w_diff;
    logic [10:0] w_sub;

    assign w_m2   = {1'b1, r_b[9:0]};
    assign w_ge   = (r_rem >= {1'b0, w_m2});
    assign w_diff = r_rem - {1'b0, w_m2};
    // Remainder is below the divisor after the step, so 11 bits suffice
    assign w_sub  = w_ge ? w_diff[10:0] : r_rem[10:0];

    // Zero/denormal or inf/NaN exponent fields bypass the iteration
    logic w_in_fast;
    assign w_in_fast = (i_Dividend[14:10] == 5'd0) || (i_Dividend[14:10] == 5'h1F) ||
                       (i_Divisor[14:10]  == 5'd0) || (i_Divisor[14:10]  == 5'h1F);

    // Normalisation of the quotient bits and exponent
    logic              w_sign;
    logic signed [6:0] w_e;
    logic [9:0]        w_frac;
    logic signed [6:0] w_e_r;
    logic [9:0]        w_frac_r;

    assign w_sign = r_a[15] ^ r_b[15];
    assign w_e    = 7'({2'b00, r_a[14:10]}) - 7'({2'b00, r_b[14:10]}) +
                    (r_q[12] ? 7'(BIAS) : 7'(BIAS - 1));
    assign w_frac = r_q[12] ? r_q[11:2] : r_q[10:1];

`ifdef DIV_ROUND_NEAREST_EN
    logic w_guard;
    logic w_sticky;
    logic w_inc;
    logic w_carry;

    assign w_guard  = r_q[12] ? r_q[1] : r_q[0];
    assign w_sticky = (r_rem != 12'd0) | (r_q[12] ? r_q[0] : 1'b0);
    assign w_inc    = w_guard & (w_sticky | w_frac[0]);
    // All-ones fraction rounding up carries into the exponent
    assign w_carry  = w_inc & (w_frac == 10'h3FF);
    assign w_frac_r = w_frac + 10'(w_inc);
    assign w_e_r    = w_e + 7'(w_carry);
`else
    logic w_unused;

    assign w_unused = &{1'b0, r_q[0]};
    assign w_frac_r = w_frac;
    assign w_e_r    = w_e;
`endif

    // Final result selection, special operands first
    logic [15:0] w_res;
    logic        w_exc;

    always_comb begin
        w_res = {w_sign, w_e_r[4:0], w_frac_r};
        w_exc = 1'b0;
        if ((r_a[14:10] == 5'h1F) || (r_b[14:10] == 5'h1F)) begin
            w_res = 16'h7E00;
            w_exc = 1'b1;
        end else if (r_b[14:10] == 5'd0) begin
            w_res = {w_sign, 15'h7C00};
            w_exc = 1'b1;
        end else if (r_a[14:10] == 5'd0) begin
            w_res = {w_sign, 15'h0000};
            w_exc = 1'b0;
        end else if (w_e_r > 7'sd30) begin
            w_res = {w_sign, 5'h1F, 10'h000};
            w_exc = 1'b1;
        end else if (w_e_r < 7'sd1) begin
            w_res = {w_sign, 15'h0000};
            w_exc = 1'b1;
        end
    end

    // Control FSM with registered outputs
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            r_state     <= S_IDLE;
            r_a         <= 16'h0000;
            r_b         <= 16'h0000;
            r_rem       <= 12'h000;
            r_q         <= 13'h0000;
            r_cnt       <= '0;
            r_res       <= 16'h0000;
            r_exc       <= 1'b0;
            o_Quotient  <= 16'h0000;
            o_Exception <= 1'b0;
            o_Busy      <= 1'b0;
            o_Done      <= 1'b0;
        end else begin
            o_Done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        r_a     <= i_Dividend;
                        r_b     <= i_Divisor;
                        r_rem   <= {2'b01, i_Dividend[9:0]};
                        r_q     <= 13'h0000;
                        r_cnt   <= '0;
                        o_Busy  <= 1'b1;
                        r_state <= w_in_fast ? S_NORM : S_ITER;
                    end
                end
                S_ITER: begin
                    r_q   <= {r_q[11:0], w_ge};
                    r_rem <= {w_sub, 1'b0};
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(ITER - 1)) begin
                        r_state <= S_NORM;
                    end
                end
                S_NORM: begin
                    r_res   <= w_res;
                    r_exc   <= w_exc;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    o_Quotient  <= r_res;
                    o_Exception <= r_exc;
                    o_Done      <= 1'b1;
                    o_Busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_half_precision.sv
// Scoreboard bench for div_half_precision: a driver issues requests and
// pushes model results; a monitor pops and compares on every o_Done.

module tb_div_half_precision;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [15:0] divisor;
    logic [15:0] quotient;
    logic        exception;
    logic        busy;
    logic        done;

    div_half_precision dut (
        .i_Clk       (clk),
        .i_Reset_n   (rst_n),
        .i_Start     (start),
        .i_Dividend  (dividend),
        .i_Divisor   (divisor),
        .o_Quotient  (quotient),
        .o_Exception (exception),
        .o_Busy      (busy),
        .o_Done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] q;
        logic        exc;
        int          due;
    } exp_t;

    exp_t sb[$];
    bit   inflight = 1'b0;

`ifdef DIV_ROUND_NEAREST_EN
    localparam bit RNE = 1'b1;
`else
    localparam bit RNE = 1'b0;
`endif

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: exact integer division of significands, then the rounding
    // and range rules applied arithmetically.
    function automatic logic [16:0] ref_div(logic [15:0] a, logic [15:0] b);
        int ea, eb, num, den, q, rem, e, frac;
        bit s, guard, sticky;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        s  = a[15] ^ b[15];
        if (ea == 31 || eb == 31) return {1'b1, 16'h7E00};
        if (eb == 0) return {1'b1, s, 15'h7C00};
        if (ea == 0) return {1'b0, s, 15'h0000};
        num = (1024 + int'(a[9:0])) * 4096;
        den = 1024 + int'(b[9:0]);
        q   = num / den;
        rem = num % den;
        if (q >= 4096) begin
            frac   = (q / 4) % 1024;
            guard  = ((q / 2) % 2) == 1;
            sticky = (rem != 0) || ((q % 2) == 1);
            e      = ea - eb + 15;
        end else begin
            frac   = (q / 2) % 1024;
            guard  = (q % 2) == 1;
            sticky = (rem != 0);
            e      = ea - eb + 14;
        end
        if (RNE && guard && (sticky || (frac % 2) == 1)) begin
            frac = frac + 1;
            if (frac == 1024) begin
                frac = 0;
                e    = e + 1;
            end
        end
        if (e > 30) return {1'b1, s, 5'h1F, 10'h000};
        if (e < 1)  return {1'b1, s, 15'h0000};
        return {1'b0, s, 5'(e), 10'(frac)};
    endfunction

    function automatic bit is_fast(logic [15:0] a, logic [15:0] b);
        return (a[14:10] == 5'd0) || (a[14:10] == 5'h1F) ||
               (b[14:10] == 5'd0) || (b[14:10] == 5'h1F);
    endfunction

    // Monitor: compares every completion against the oldest expectation
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk($sformatf("quot %h/%h", e.a, e.b), 32'(quotient), 32'(e.q));
                    chk($sformatf("exc %h/%h", e.a, e.b), 32'(exception), 32'(e.exc));
                    chk($sformatf("latency %h/%h", e.a, e.b), 32'(cyc), 32'(e.due));
                    chk("busy_low_at_done", 32'(busy), 32'd0);
                end
                inflight = 1'b0;
            end else if (inflight) begin
                chk("busy_while_inflight", 32'(busy), 32'd1);
            end
        end
    end

    // Issue one request from a negedge; returns at the following negedge
    task automatic issue(input logic [15:0] a, input logic [15:0] b);
        int   n;
        exp_t e;
        logic [16:0] r;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("wait_not_busy_timeout", 32'(busy), 32'd0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 16'($urandom);
        divisor  = 16'($urandom);
        r     = ref_div(a, b);
        e.a   = a;
        e.b   = b;
        e.q   = r[15:0];
        e.exc = r[16];
        e.due = cyc + (is_fast(a, b) ? 2 : 15);
        sb.push_back(e);
        inflight = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk("done_timeout", 32'(done), 32'd1);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_half();
        logic [4:0] e;
        int unsigned k;
        k = $urandom_range(0, 9);
        if (k == 0)      e = 5'd0;
        else if (k == 1) e = 5'h1F;
        else             e = 5'($urandom_range(1, 30));
        return {1'($urandom), e, 10'($urandom)};
    endfunction

    logic [15:0] dir_a[10] = '{16'h4400, 16'h4500, 16'hC400, 16'h3C00, 16'h7800,
                               16'h0400, 16'h7C00, 16'h0000, 16'h3C00, 16'h4BFF};
    logic [15:0] dir_b[10] = '{16'h4000, 16'h4200, 16'h4000, 16'h0000, 16'h0400,
                               16'h7800, 16'h3C00, 16'h4000, 16'h3C01, 16'h4400};

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 16'h0000;
        divisor  = 16'h0000;
        repeat (3) @(negedge clk);
        chk("reset_quot", 32'(quotient), 32'd0);
        chk("reset_exc", 32'(exception), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases, issued back to back
        for (int i = 0; i < 10; i++) issue(dir_a[i], dir_b[i]);
        wait_done();

        // Starts while busy must be ignored
        issue(16'h4400, 16'h4000);
        for (int k = 2; k <= 8; k++) begin
            if (k == 3 || k == 7) begin
                start    = 1'b1;
                dividend = 16'h4500;
                divisor  = 16'h4200;
            end
            @(negedge clk);
            start = 1'b0;
        end
        wait_done();
        repeat (3) @(negedge clk);
        chk("no_extra_done", 32'(sb.size()), 32'd0);

        // Reset mid-operation aborts with no completion
        issue(16'h4400, 16'h4000);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_quot", 32'(quotient), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        sb.delete();
        inflight = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_no_done_busy", 32'(busy), 32'd0);
        issue(16'h4400, 16'h4000);
        wait_done();

        // Randomised requests with random gaps
        for (int i = 0; i < 200; i++) begin
            issue(rand_half(), rand_half());
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_done();
        repeat (5) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
